// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

    localparam int NREQ_DEF     = 4;
    localparam int BAUD_DIV_DEF = 27;
    localparam int TMO_DEF      = 255;

    // IDLE: unowned; LOCK: owner may send; GAP: wait for tx_full to settle;
    // FLUSH: transmitter clear in progress.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK  = 2'd1,
        ST_GAP   = 2'd2,
        ST_FLUSH = 2'd3
    } arb_state_t;

    // Width of an index or counter covering 0..n-1, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester, transmitter and status signals of the UART transmit arbiter.
// Handshake: a requester holds req/req_data/req_last stable while req is high
// until it sees its req_ack pulse; a byte transfers in the cycle req_ack is
// high (tx_wr is high in that same cycle). The next byte must be presented by
// the clock edge that ends the req_ack cycle.
interface uart_tx_arbiter_if
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) ();
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ack;
    logic [NREQ-1:0]   grant;
    logic              flush;
    logic              tx_wr;
    logic [7:0]        tx_di;
    logic              tx_full;
    logic              tx_clear;
    logic              baud16x_ce;
    logic              busy;
    arb_state_t        dbg_state;

    // The arbiter itself.
    modport slave (
        input  req, req_data, req_last, flush, tx_full,
        output req_ack, grant, tx_wr, tx_di, tx_clear, baud16x_ce, busy, dbg_state
    );

    // The requesters plus the transmitter it feeds.
    modport master (
        output req, req_data, req_last, flush, tx_full,
        input  req_ack, grant, tx_wr, tx_di, tx_clear, baud16x_ce, busy, dbg_state
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: the first requester after ptr
// (wrapping modulo NREQ) wins; ptr itself is considered last.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   win_idx,
    output logic            any
);
    logic [IW-1:0] cand;

    // Scan ptr+1 .. ptr+NREQ and keep the first active request.
    always_comb begin
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (!any && req[cand]) begin
                any       = 1'b1;
                win[cand] = 1'b1;
                win_idx   = cand;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter FIFO between NREQ byte streams with
// round-robin, message-locked arbitration, an idle timeout, flush
// sequencing and the baud x16 clock enable. All outputs are registered.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int BAUD_DIV = BAUD_DIV_DEF,
    parameter int TMO      = TMO_DEF
) (
    input logic             clk,
    input logic             reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int IW = idx_width(NREQ);
    localparam int BW = idx_width(BAUD_DIV);
    localparam int TW = idx_width(TMO);

    arb_state_t            state_q, state_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [IW-1:0]         gidx_q, gidx_d;
    logic [NREQ-1:0]       grant_q, grant_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  tx_wr_q, tx_wr_d;
    logic [7:0]            tx_di_q, tx_di_d;
    logic [NREQ-1:0]       ack_q, ack_d;
    logic                  clear_q, clear_d;
    logic                  busy_q;
    logic [BW-1:0]         baud_cnt, baud_cnt_d;
    logic                  baud_ce_q;
    logic [NREQ-1:0]       pick_win;
    logic [IW-1:0]         pick_idx;
    logic                  pick_any;
    logic [NREQ-1:0][7:0]  req_bytes;

    assign req_bytes = bus.req_data;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .win     (pick_win),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    // Free-running baud divider: 0..BAUD_DIV-1, wraps.
    always_comb begin
        baud_cnt_d = (baud_cnt == BW'(BAUD_DIV - 1)) ? '0 : baud_cnt + 1'b1;
    end

    // Register the divider; the enable is aligned with the terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt  <= '0;
            baud_ce_q <= 1'b0;
        end else begin
            baud_cnt  <= baud_cnt_d;
            baud_ce_q <= (baud_cnt_d == BW'(BAUD_DIV - 1));
        end
    end

    // Arbitration next state and next registered outputs; flush wins over all.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        grant_d = grant_q;
        timer_d = timer_q;
        tx_wr_d = 1'b0;
        tx_di_d = tx_di_q;
        ack_d   = '0;
        clear_d = 1'b0;
        if (bus.flush) begin
            state_d = ST_FLUSH;
            grant_d = '0;
            timer_d = '0;
            clear_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        state_d = ST_LOCK;
                        grant_d = pick_win;
                        gidx_d  = pick_idx;
                        timer_d = '0;
                    end
                end
                ST_LOCK: begin
                    if (bus.req[gidx_q]) begin
                        // A full FIFO stalls the owner without aging its lock.
                        if (!bus.tx_full) begin
                            tx_wr_d = 1'b1;
                            tx_di_d = req_bytes[gidx_q];
                            ack_d   = grant_q;
                            timer_d = '0;
                            if (bus.req_last[gidx_q]) begin
                                grant_d = '0;
                                ptr_d   = gidx_q;
                                state_d = ST_IDLE;
                            end else begin
                                state_d = ST_GAP;
                            end
                        end
                    end else if (timer_q == TW'(TMO - 2)) begin
                        // This idle cycle brings the count to TMO-1: release.
                        grant_d = '0;
                        ptr_d   = gidx_q;
                        timer_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    state_d = ST_LOCK;
                end
                ST_FLUSH: begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= IW'(NREQ - 1);
            gidx_q  <= '0;
            grant_q <= '0;
            timer_q <= '0;
            tx_wr_q <= 1'b0;
            tx_di_q <= '0;
            ack_q   <= '0;
            clear_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
            timer_q <= timer_d;
            tx_wr_q <= tx_wr_d;
            tx_di_q <= tx_di_d;
            ack_q   <= ack_d;
            clear_q <= clear_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign bus.grant      = grant_q;
    assign bus.req_ack    = ack_q;
    assign bus.tx_wr      = tx_wr_q;
    assign bus.tx_di      = tx_di_q;
    assign bus.tx_clear   = clear_q;
    assign bus.busy       = busy_q;
    assign bus.baud16x_ce = baud_ce_q;
    assign bus.dbg_state  = state_q;
endmodule
